// File: rtl/safety_monitor.sv
// Grid/relay safety monitor: debounces abnormal grid samples into faults, enforces
// a recovery holdoff, locks out after repeated faults or a persistent relay mismatch.
module safety_monitor #(
    parameter int unsigned DEBOUNCE_CYCLES       = 4,
    parameter int unsigned HOLDOFF_CYCLES        = 16,
    parameter int unsigned MAX_RETRIES           = 3,
    parameter int unsigned RELAY_MISMATCH_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] grid_state,
    input  logic       charge_enable,
    input  logic       relay_activation,
    input  logic       fault_clear,
    output logic       fault_flag,
    output logic [1:0] fault_cause,
    output logic       locked_out,
    output logic [7:0] fault_count
);

    typedef enum logic [2:0] {
        ST_MONITOR = 3'd0,
        ST_PENDING = 3'd1,
        ST_FAULT   = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [1:0] GRID_NORMAL  = 2'b00;
    localparam logic [1:0] GRID_SAG     = 2'b01;
    localparam logic [1:0] GRID_SWELL   = 2'b10;
    localparam logic [1:0] GRID_OUTAGE  = 2'b11;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_SAGSW  = 2'b01;
    localparam logic [1:0] CAUSE_OUTAGE = 2'b10;
    localparam logic [1:0] CAUSE_RELAY  = 2'b11;

    localparam logic [7:0] DEBOUNCE_LIMIT = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] HOLDOFF_LIMIT  = 8'(HOLDOFF_CYCLES);
    localparam logic [3:0] RETRY_LIMIT    = 4'(MAX_RETRIES);
    localparam logic [7:0] MISMATCH_LIMIT = 8'(RELAY_MISMATCH_CYCLES);

    state_t     state_r, next_state_s;
    logic [7:0] debounce_cnt_r, next_debounce_s;
    logic [7:0] holdoff_cnt_r, next_holdoff_s;
    logic [3:0] retry_cnt_r, next_retry_s;
    logic [7:0] mismatch_cnt_r, next_mismatch_s;
    logic [1:0] fault_cause_r, next_cause_s;
    logic [7:0] fault_count_r, next_count_s;
    logic       fault_flag_r;
    logic       locked_out_r;

    logic       grid_abnormal_s;
    logic       grid_outage_s;
    logic       grid_normal_s;
    logic [1:0] grid_class_s;
    logic       mismatch_s;
    logic [7:0] mismatch_inc_s;
    logic       relay_trip_s;
    logic       grid_entry_s;
    logic [3:0] retry_inc_s;
    logic [7:0] fault_count_sat_s;
    logic [7:0] debounce_inc_s;
    logic [7:0] holdoff_inc_s;

    assign grid_outage_s     = (grid_state == GRID_OUTAGE);
    assign grid_normal_s     = (grid_state == GRID_NORMAL);
    assign grid_abnormal_s   = (grid_state == GRID_SAG) || (grid_state == GRID_SWELL);
    assign grid_class_s      = grid_outage_s ? CAUSE_OUTAGE : CAUSE_SAGSW;
    assign mismatch_s        = relay_activation & ~charge_enable;
    assign mismatch_inc_s    = mismatch_cnt_r + 8'd1;
    assign relay_trip_s      = (state_r != ST_LOCKOUT) && mismatch_s && (mismatch_inc_s == MISMATCH_LIMIT);
    assign debounce_inc_s    = debounce_cnt_r + 8'd1;
    assign holdoff_inc_s     = holdoff_cnt_r + 8'd1;
    assign retry_inc_s       = retry_cnt_r + 4'd1;
    assign fault_count_sat_s = (fault_count_r == 8'hFF) ? 8'hFF : (fault_count_r + 8'd1);

    // A new (counted) grid fault is raised only from the non-faulted states.
    assign grid_entry_s = ((state_r == ST_MONITOR) && grid_outage_s) ||
                          ((state_r == ST_PENDING) &&
                           (grid_outage_s || (grid_abnormal_s && (debounce_inc_s == DEBOUNCE_LIMIT))));

    // Next-state and counter computation; relay trip outranks any grid event.
    always_comb begin
        next_state_s    = state_r;
        next_debounce_s = debounce_cnt_r;
        next_holdoff_s  = holdoff_cnt_r;
        next_retry_s    = retry_cnt_r;
        next_cause_s    = fault_cause_r;
        next_count_s    = fault_count_r;
        next_mismatch_s = (state_r == ST_LOCKOUT) ? 8'd0 : (mismatch_s ? mismatch_inc_s : 8'd0);

        if (relay_trip_s) begin
            next_state_s    = ST_LOCKOUT;
            next_cause_s    = CAUSE_RELAY;
            next_debounce_s = 8'd0;
            next_holdoff_s  = 8'd0;
            next_mismatch_s = 8'd0;
        end else if (grid_entry_s) begin
            next_count_s    = fault_count_sat_s;
            next_retry_s    = retry_inc_s;
            next_cause_s    = grid_class_s;
            next_debounce_s = 8'd0;
            next_holdoff_s  = 8'd0;
            next_state_s    = (retry_inc_s == RETRY_LIMIT) ? ST_LOCKOUT : ST_FAULT;
        end else begin
            case (state_r)
                ST_MONITOR: begin
                    if (grid_abnormal_s) begin
                        next_state_s    = ST_PENDING;
                        next_debounce_s = 8'd1;
                    end else begin
                        next_debounce_s = 8'd0;
                    end
                end
                ST_PENDING: begin
                    if (grid_abnormal_s) begin
                        next_debounce_s = debounce_inc_s;
                    end else begin
                        next_state_s    = ST_MONITOR;
                        next_debounce_s = 8'd0;
                    end
                end
                ST_FAULT: begin
                    if (grid_normal_s) begin
                        next_state_s   = ST_HOLDOFF;
                        next_holdoff_s = 8'd1;
                    end else begin
                        next_cause_s   = grid_class_s;
                    end
                end
                ST_HOLDOFF: begin
                    if (!grid_normal_s) begin
                        next_state_s   = ST_FAULT;
                        next_cause_s   = grid_class_s;
                        next_holdoff_s = 8'd0;
                    end else if (holdoff_inc_s == HOLDOFF_LIMIT) begin
                        next_state_s   = ST_MONITOR;
                        next_cause_s   = CAUSE_NONE;
                        next_holdoff_s = 8'd0;
                    end else begin
                        next_holdoff_s = holdoff_inc_s;
                    end
                end
                ST_LOCKOUT: begin
                    if (fault_clear && grid_normal_s && !mismatch_s) begin
                        next_state_s    = ST_MONITOR;
                        next_cause_s    = CAUSE_NONE;
                        next_retry_s    = 4'd0;
                        next_mismatch_s = 8'd0;
                    end else begin
                        next_state_s    = ST_LOCKOUT;
                    end
                end
                default: begin
                    next_state_s    = ST_MONITOR;
                    next_debounce_s = 8'd0;
                    next_holdoff_s  = 8'd0;
                    next_cause_s    = CAUSE_NONE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_MONITOR;
            debounce_cnt_r <= 8'd0;
            holdoff_cnt_r  <= 8'd0;
            retry_cnt_r    <= 4'd0;
            mismatch_cnt_r <= 8'd0;
            fault_cause_r  <= CAUSE_NONE;
            fault_count_r  <= 8'd0;
            fault_flag_r   <= 1'b0;
            locked_out_r   <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            debounce_cnt_r <= next_debounce_s;
            holdoff_cnt_r  <= next_holdoff_s;
            retry_cnt_r    <= next_retry_s;
            mismatch_cnt_r <= next_mismatch_s;
            fault_cause_r  <= next_cause_s;
            fault_count_r  <= next_count_s;
            fault_flag_r   <= (next_state_s == ST_FAULT) || (next_state_s == ST_HOLDOFF) ||
                              (next_state_s == ST_LOCKOUT);
            locked_out_r   <= (next_state_s == ST_LOCKOUT);
        end
    end

    assign fault_flag  = fault_flag_r;
    assign fault_cause = fault_cause_r;
    assign locked_out  = locked_out_r;
    assign fault_count = fault_count_r;

endmodule

// File: tb/tb_safety_monitor.sv
// Directed and randomized bench for safety_monitor against a run-length based
// reference model of the fault/holdoff/lockout rules.
module tb_safety_monitor;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int MAXR = 3;
    localparam int RMC  = 8;

    logic       clk;
    logic       reset;
    logic [1:0] grid_state;
    logic       charge_enable;
    logic       relay_activation;
    logic       fault_clear;
    logic       fault_flag;
    logic [1:0] fault_cause;
    logic       locked_out;
    logic [7:0] fault_count;

    safety_monitor #(
        .DEBOUNCE_CYCLES      (DEB),
        .HOLDOFF_CYCLES       (HOLD),
        .MAX_RETRIES          (MAXR),
        .RELAY_MISMATCH_CYCLES(RMC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .grid_state      (grid_state),
        .charge_enable   (charge_enable),
        .relay_activation(relay_activation),
        .fault_clear     (fault_clear),
        .fault_flag      (fault_flag),
        .fault_cause     (fault_cause),
        .locked_out      (locked_out),
        .fault_count     (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: run lengths of abnormal / normal / mismatch samples.
    bit m_locked, m_faulted;
    int m_abn, m_norm, m_mis, m_retries, m_cause, m_count;

    task automatic model_reset();
        m_locked = 0; m_faulted = 0; m_abn = 0; m_norm = 0;
        m_mis = 0; m_retries = 0; m_cause = 0; m_count = 0;
    endtask

    task automatic model_step(input logic rst, input logic [1:0] g, input logic en,
                              input logic rl, input logic clr);
        bit mis_now;
        mis_now = rl && !en;
        if (rst) begin
            model_reset();
        end else if (m_locked) begin
            if (clr && g == 2'd0 && !mis_now) model_reset_keep_count();
        end else begin
            m_mis = mis_now ? m_mis + 1 : 0;
            if (m_mis == RMC) begin
                m_locked = 1; m_faulted = 0; m_cause = 3;
                m_abn = 0; m_norm = 0; m_mis = 0;
            end else if (!m_faulted) begin
                if (g == 2'd3 || (g != 2'd0 && m_abn + 1 == DEB)) begin
                    m_count   = (m_count < 255) ? m_count + 1 : 255;
                    m_retries = m_retries + 1;
                    m_cause   = (g == 2'd3) ? 2 : 1;
                    m_abn = 0; m_norm = 0;
                    if (m_retries == MAXR) m_locked = 1;
                    else m_faulted = 1;
                end else if (g != 2'd0) begin
                    m_abn = m_abn + 1;
                end else begin
                    m_abn = 0;
                end
            end else begin
                if (g == 2'd0) begin
                    m_norm = m_norm + 1;
                    if (m_norm == HOLD) begin
                        m_faulted = 0; m_cause = 0; m_norm = 0;
                    end
                end else begin
                    m_norm  = 0;
                    m_cause = (g == 2'd3) ? 2 : 1;
                end
            end
        end
    endtask

    task automatic model_reset_keep_count();
        int keep;
        keep = m_count;
        model_reset();
        m_count = keep;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge.
    task automatic apply(input logic rst, input logic [1:0] g, input logic en,
                         input logic rl, input logic clr);
        reset = rst; grid_state = g; charge_enable = en;
        relay_activation = rl; fault_clear = clr;
        @(posedge clk);
        #1;
        model_step(rst, g, en, rl, clr);
        n_vec++;
        chk("fault_flag",  32'(fault_flag),  32'(m_faulted || m_locked));
        chk("locked_out",  32'(locked_out),  32'(m_locked));
        chk("fault_cause", 32'(fault_cause), 32'(m_cause));
        chk("fault_count", 32'(fault_count), 32'(m_count));
    endtask

    task automatic run(input int n, input logic [1:0] g, input logic en, input logic rl,
                       input logic clr);
        for (int i = 0; i < n; i++) apply(1'b0, g, en, rl, clr);
    endtask

    initial begin
        logic [1:0] rg;
        logic       ren, rrl;
        int         len;

        model_reset();
        apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_outputs", {22'd0, fault_flag, locked_out, fault_cause, fault_count}, 32'd0);

        // Debounce: 3 SAG is not enough, 4 mixed SAG/SWELL is.
        run(3, 2'd1, 1'b0, 1'b0, 1'b0);
        run(1, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("deb3_flag", 32'(fault_flag), 32'd0);
        run(1, 2'd1, 1'b0, 1'b0, 1'b0);
        run(1, 2'd2, 1'b0, 1'b0, 1'b0);
        run(2, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("deb4_flag",  32'(fault_flag),  32'd1);
        chk("deb4_cause", 32'(fault_cause), 32'd1);
        chk("deb4_count", 32'(fault_count), 32'd1);
        run(2, 2'd3, 1'b0, 1'b0, 1'b0);
        chk("fault_outage_cause", 32'(fault_cause), 32'd2);
        run(HOLD, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("holdoff_exit_flag", 32'(fault_flag), 32'd0);

        // Outage with an interrupted holdoff.
        apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        run(1, 2'd3, 1'b0, 1'b0, 1'b0);
        chk("outage_flag",  32'(fault_flag),  32'd1);
        chk("outage_cause", 32'(fault_cause), 32'd2);
        run(15, 2'd0, 1'b0, 1'b0, 1'b0);
        run(1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("holdoff_break_cause", 32'(fault_cause), 32'd1);
        run(15, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("holdoff_15_flag", 32'(fault_flag), 32'd1);
        run(1, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("holdoff_16_flag",  32'(fault_flag),  32'd0);
        chk("holdoff_16_count", 32'(fault_count), 32'd1);

        // Retry lockout and clear qualification.
        apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) begin
            run(4, 2'd1, 1'b0, 1'b0, 1'b0);
            if (e < 2) run(HOLD, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        chk("lock_locked", 32'(locked_out),  32'd1);
        chk("lock_count",  32'(fault_count), 32'd3);
        run(1, 2'd0, 1'b0, 1'b0, 1'b0);
        run(1, 2'd1, 1'b0, 1'b0, 1'b1);
        chk("clear_sag_ignored", 32'(locked_out), 32'd1);
        run(1, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("clear_mismatch_ignored", 32'(locked_out), 32'd1);
        run(1, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("clear_ok_locked", 32'(locked_out), 32'd0);
        chk("clear_ok_flag",   32'(fault_flag), 32'd0);
        run(1, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("clear_outside_lockout", 32'(fault_flag), 32'd0);

        // Relay mismatch: 7 then recovery, then 8.
        run(7, 2'd0, 1'b0, 1'b1, 1'b0);
        run(1, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("relay7_flag", 32'(fault_flag), 32'd0);
        run(7, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("relay7b_flag", 32'(fault_flag), 32'd0);
        run(1, 2'd3, 1'b0, 1'b1, 1'b0);
        chk("relay8_locked", 32'(locked_out),  32'd1);
        chk("relay8_cause",  32'(fault_cause), 32'd3);
        run(1, 2'd0, 1'b0, 1'b0, 1'b1);

        // Reset from HOLDOFF, from LOCKOUT, and together with OUTAGE.
        run(1, 2'd3, 1'b0, 1'b0, 1'b0);
        run(3, 2'd0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_holdoff", {22'd0, fault_flag, locked_out, fault_cause, fault_count}, 32'd0);
        run(RMC, 2'd0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_lockout", {22'd0, fault_flag, locked_out, fault_cause, fault_count}, 32'd0);
        apply(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        chk("reset_outage", {22'd0, fault_flag, locked_out, fault_cause, fault_count}, 32'd0);

        // fault_count saturation.
        for (int k = 0; k < 270; k++) begin
            if (m_locked) run(1, 2'd0, 1'b0, 1'b0, 1'b1);
            run(1, 2'd3, 1'b0, 1'b0, 1'b0);
            if (!m_locked) run(HOLD, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        chk("count_saturated", 32'(fault_count), 32'd255);

        // Randomized bursts of grid state and relay behaviour.
        for (int b = 0; b < 400; b++) begin
            rg  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) rg = 2'd0;
            len = $urandom_range(1, 20);
            rrl = ($urandom_range(0, 5) == 0);
            ren = rrl ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                apply(($urandom_range(0, 599) == 0), rg, ren, rrl,
                      ($urandom_range(0, 3) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/safety_monitor.md
SAFETY_MONITOR -- requirements
Module: safety_monitor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive abnormal grid samples needed to raise a fault (legal 2..255).
REQ-002 Parameter HOLDOFF_CYCLES, default 16: consecutive NORMAL samples needed to clear a fault (legal 2..255).
REQ-003 Parameter MAX_RETRIES, default 3: grid faults allowed before lockout (legal 1..15).
REQ-004 Parameter RELAY_MISMATCH_CYCLES, default 8: consecutive relay-without-enable samples needed to force lockout (legal 2..255).
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 grid_state  input  grid_state_t (2)  NORMAL=00, SAG=01, SWELL=10, OUTAGE=11.
REQ-008 charge_enable  input  1  charge FSM enable, monitored.
REQ-009 relay_activation  input  1  relay drive from charge FSM, monitored.
REQ-010 fault_clear  input  1  operator clear, single-cycle pulse.
REQ-011 fault_flag  output  1  drives the safety-side fault_flag consumed by the charge FSM.
REQ-012 fault_cause  output  2  00 none, 01 sag/swell, 10 outage, 11 relay mismatch.
REQ-013 locked_out  output  1  high in LOCKOUT only.
REQ-014 fault_count  output  8  total faults since reset, saturating at 255.

Function
REQ-015 All outputs SHALL be registered; an output change SHALL be visible after the clock edge that samples its cause.
REQ-016 States: MONITOR, PENDING, FAULT, HOLDOFF, LOCKOUT; fault_flag=0 in MONITOR/PENDING, 1 in FAULT/HOLDOFF/LOCKOUT.
REQ-017 MONITOR: SAG/SWELL -> PENDING with debounce count=1; OUTAGE -> FAULT immediately (cause 10); NORMAL -> stay.
REQ-018 PENDING: SAG/SWELL -> count+1, entering FAULT (cause 01) at the DEBOUNCE_CYCLES-th consecutive sample; OUTAGE -> FAULT (cause 10); NORMAL -> MONITOR, count cleared.
REQ-019 Mixed SAG and SWELL samples SHALL count as consecutive abnormal samples.
REQ-020 Each entry to FAULT from MONITOR/PENDING SHALL increment fault_count (saturating) and the internal retry counter.
REQ-021 Entry to FAULT that makes retry counter equal MAX_RETRIES SHALL go to LOCKOUT instead, keeping that entry's cause.
REQ-022 FAULT: abnormal -> stay, cause updated to the current abnormal class; NORMAL -> HOLDOFF with holdoff count=1.
REQ-023 HOLDOFF: NORMAL -> count+1, entering MONITOR at the HOLDOFF_CYCLES-th consecutive NORMAL (fault_cause -> 00); any abnormal -> FAULT without incrementing counters.
REQ-024 Relay check: relay_activation=1 with charge_enable=0 increments the mismatch counter in every non-LOCKOUT state; any other combination clears it.
REQ-025 Mismatch counter reaching RELAY_MISMATCH_CYCLES SHALL force LOCKOUT with cause 11 from any state.
REQ-026 A relay lockout and a grid fault on the same edge SHALL resolve to LOCKOUT with cause 11.
REQ-027 LOCKOUT exits to MONITOR only on a fault_clear sample with grid_state=NORMAL and no relay mismatch; this clears retry counter, mismatch counter, fault_cause.
REQ-028 fault_clear outside LOCKOUT, or with clear conditions unmet, SHALL be ignored.
REQ-029 fault_count SHALL be cleared only by reset.

Reset
REQ-030 reset SHALL take precedence over all inputs, forcing MONITOR, all counters 0, fault_flag=0, fault_cause=00, locked_out=0, fault_count=0 on the next edge, including mid-fault or in LOCKOUT.

Verification
REQ-031 SAG for 3 cycles then NORMAL -> fault_flag stays 0; SAG for 4 cycles -> fault_flag=1, cause 01, fault_count=1 after the 4th edge.
REQ-032 OUTAGE for 1 cycle from MONITOR -> fault_flag=1, cause 10 after that edge; then 15 NORMAL, 1 SAG, 16 NORMAL -> fault_flag=0 only after the final 16th NORMAL, fault_count still 1.
REQ-033 Three separate 4-cycle SAG events with full holdoff between -> third event gives locked_out=1, fault_count=3; fault_clear with SAG present ignored; fault_clear with NORMAL -> MONITOR.
REQ-034 relay_activation=1, charge_enable=0 for 8 cycles -> LOCKOUT, cause 11; for 7 cycles then charge_enable=1 -> no fault.
REQ-035 reset asserted in HOLDOFF and in LOCKOUT -> all outputs 0 on the next edge; reset and OUTAGE on the same edge -> outputs 0.
